// File: rtl/rv32i_pkg.sv
// rv32i_pkg: fetch defaults, BTB entry layout and 2-bit counter training helper
package rv32i_pkg;
   localparam logic [31:0] START_PC = 32'h0000_8000;
   localparam int BTB_ENTRIES = 16;
   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      cnt_e        cnt;
   } btb_entry_t;
   function automatic cnt_e cnt_train(cnt_e c, logic taken);
      return taken ? (c == CNT_ST ? CNT_ST : cnt_e'(c + 2'd1))
                   : (c == CNT_SNT ? CNT_SNT : cnt_e'(c - 2'd1));
   endfunction
endpackage

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, lookup on fetch PC, training from execute
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_pc,
   output logic        o_predict_taken,
   output logic [31:0] o_target,
   input  logic        i_upd_en,
   input  logic [31:0] i_upd_pc,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_target
);
   import rv32i_pkg::*;
   localparam int IW = $clog2(ENTRIES);
   btb_entry_t       r_btb [ENTRIES];
   btb_entry_t       w_rd;
   btb_entry_t       w_ud;
   logic [IW-1:0]    w_uidx;
   logic [29:0]      w_utag;
   logic             w_uhit;
   always_comb begin
      w_rd            = r_btb[i_pc[IW+1:2]];
      w_uidx          = i_upd_pc[IW+1:2];
      w_utag          = 30'(i_upd_pc[31:IW+2]);
      w_ud            = r_btb[w_uidx];
      w_uhit          = w_ud.valid && w_ud.tag == w_utag;
      o_predict_taken = w_rd.valid && w_rd.tag == 30'(i_pc[31:IW+2]) && w_rd.cnt[1] && i_pc[1:0] == 2'b00;
      o_target        = w_rd.target;
   end
   // only valid bits are reset; a written entry is seen by lookups from the next cycle on
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) r_btb[i].valid <= 1'b0;
      end else if (i_upd_en && w_uhit) begin
         r_btb[w_uidx].cnt <= cnt_train(w_ud.cnt, i_upd_taken);
         if (i_upd_taken) r_btb[w_uidx].target <= i_upd_target;
      end else if (i_upd_en && i_upd_taken) begin
         r_btb[w_uidx] <= '{valid: 1'b1, tag: w_utag, target: i_upd_target, cnt: CNT_WT};
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and next-PC selection feeding a 1-cycle synchronous instruction memory
module fetch_stage #(
   parameter logic [31:0] START_PC    = rv32i_pkg::START_PC,
   parameter int          BTB_ENTRIES = rv32i_pkg::BTB_ENTRIES
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        stall,
   input  logic        fail_predictD,
   input  logic        fail_predictE,
   input  logic [31:0] nextpc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pcF,
   output logic [31:0] instF,
   output logic        predict_takenF,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] w_btb_target;
   logic        w_pred;
   branch_predictor #(.ENTRIES(BTB_ENTRIES)) u_bp (
      .clk            (CLK),
      .rst            (RST),
      .i_pc           (r_pc),
      .o_predict_taken(w_pred),
      .o_target       (w_btb_target),
      .i_upd_en       (upd_en),
      .i_upd_pc       (upd_pc),
      .i_upd_taken    (upd_taken),
      .i_upd_target   (upd_target)
   );
   // redirect outranks stall so a squashed, stalled fetch still moves to the target
   always_comb begin
      w_pc_next = RST                            ? START_PC
                : (fail_predictD | fail_predictE) ? nextpc
                : stall                          ? r_pc
                : w_pred                         ? w_btb_target
                :                                  r_pc + 32'd4;
   end
   always_ff @(posedge CLK) r_pc <= w_pc_next;
   assign imem_addr      = w_pc_next;
   assign pcF            = r_pc;
   assign instF          = imem_rdata;
   assign predict_takenF = w_pred;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch/BTB stimulus checked through a scoreboard against a table-level model
module tb_fetch_stage;
   localparam logic [31:0] START = 32'h0000_8000;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        stall = 1'b0, fail_predictD = 1'b0, fail_predictE = 1'b0;
   logic [31:0] nextpc = '0;
   logic [31:0] imem_addr, imem_rdata, pcF, instF;
   logic        predict_takenF;
   logic        upd_en = 1'b0, upd_taken = 1'b0;
   logic [31:0] upd_pc = '0, upd_target = '0;
   always #5 CLK = ~CLK;

   fetch_stage dut (
      .CLK(CLK), .RST(RST), .stall(stall), .fail_predictD(fail_predictD),
      .fail_predictE(fail_predictE), .nextpc(nextpc), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .pcF(pcF), .instF(instF), .predict_takenF(predict_takenF),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
   );

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction
   always @(posedge CLK) imem_rdata <= mem_word(imem_addr);

   // reference: 16-slot table indexed by word address, tag is the remaining upper bits
   logic        m_v   [16] = '{default: 1'b0};
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_cnt [16];
   logic [31:0] m_pc;

   function automatic int m_idx(logic [31:0] pc);
      return int'((pc >> 2) & 32'hF);
   endfunction
   function automatic logic m_pred(logic [31:0] pc);
      int i = m_idx(pc);
      return m_v[i] && m_tag[i] == (pc >> 6) && m_cnt[i] >= 2 && pc[1:0] == 2'b00;
   endfunction

   typedef struct {logic [31:0] pc; logic pred; logic [31:0] inst;} exp_t;
   exp_t q[$];
   int n_cmp = 0, n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic rs, input logic st, input logic fd, input logic fe,
                       input logic [31:0] npc, input logic ue, input logic [31:0] up,
                       input logic ut, input logic [31:0] utg);
      logic [31:0] nxt;
      int i;
      @(negedge CLK);
      RST = rs; stall = st; fail_predictD = fd; fail_predictE = fe; nextpc = npc;
      upd_en = ue; upd_pc = up; upd_taken = ut; upd_target = utg;
      if (rs) nxt = START;
      else if (fd || fe) nxt = npc;
      else if (st) nxt = m_pc;
      else if (m_pred(m_pc)) nxt = m_tgt[m_idx(m_pc)];
      else nxt = m_pc + 32'd4;
      i = m_idx(up);
      if (rs) begin
         for (int k = 0; k < 16; k++) m_v[k] = 1'b0;
      end else if (ue) begin
         if (m_v[i] && m_tag[i] == (up >> 6)) begin
            if (ut) begin
               m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
               m_tgt[i] = utg;
            end else m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
         end else if (ut) begin
            m_v[i] = 1'b1; m_tag[i] = up >> 6; m_tgt[i] = utg; m_cnt[i] = 2;
         end
      end
      m_pc = nxt;
      q.push_back('{nxt, m_pred(nxt), mem_word(nxt)});
   endtask

   task automatic run(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic redirect(input logic [31:0] a);
      step(0, 0, 0, 1, a, 0, 0, 0, 0);
   endtask
   task automatic train(input logic [31:0] a, input logic t, input logic [31:0] tg);
      step(0, 1, 0, 0, 0, 1, a, t, tg);
   endtask

   initial begin : monitor
      logic [31:0] a;
      exp_t e;
      forever begin
         @(negedge CLK);
         #4 a = imem_addr;
         @(posedge CLK);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            check("imem_addr", a, e.pc);
            check("pcF", pcF, e.pc);
            check("predict_takenF", {31'b0, predict_takenF}, {31'b0, e.pred});
            check("instF", instF, e.inst);
         end
      end
   end

   initial begin : stimulus
      logic [31:0] npc, up;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      run(2);
      repeat (3) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 32'h8100, 0, 0, 0, 0);
      train(32'h8010, 1, 32'h8040);
      redirect(32'h8010);
      run(2);
      train(32'h8010, 0, 32'h0);
      redirect(32'h8010);
      run(1);
      repeat (3) train(32'h8010, 1, 32'h8040);
      redirect(32'h8010);
      run(2);
      repeat (3) train(32'h8010, 0, 32'h0);
      redirect(32'h8010);
      run(1);
      train(32'h8050, 1, 32'h8080);
      redirect(32'h8010);
      run(1);
      redirect(32'h8050);
      run(2);
      redirect(32'h8052);
      run(2);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 32'h8050, 1, 32'h8050, 1, 32'h9000);
      run(3);
      redirect(32'hFFFF_FFFC);
      run(2);
      for (int n = 0; n < 3000; n++) begin
         npc = 32'h8000 + (32'($urandom_range(0, 63)) << 2);
         if ($urandom_range(0, 99) < 5) npc[1:0] = 2'($urandom);
         up = 32'h8000 + (32'($urandom_range(0, 63)) << 2);
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 7, $urandom_range(0, 99) < 7, npc,
              $urandom_range(0, 99) < 40, up, $urandom_range(0, 99) < 60,
              32'h8000 + (32'($urandom_range(0, 63)) << 2));
      end
      @(posedge CLK);
      #3;
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: START_PC, default 32'h00008000, PC loaded on reset.
REQ-002 Parameter: BTB_ENTRIES, default 16, number of predictor entries (power of two).
REQ-003 Clock and reset SHALL be: CLK in 1 rising-edge clock; RST in 1 reset, synchronous, active-high.
REQ-004 stall  in  1  hold fetch PC (hazard from decode).
REQ-005 fail_predictD  in  1  mispredict/redirect detected in decode.
REQ-006 fail_predictE  in  1  mispredict/redirect detected in execute.
REQ-007 nextpc  in  32  redirect target, valid when either fail input is high.
REQ-008 imem_addr  out  32  instruction memory read address (memory has 1-cycle synchronous read).
REQ-009 imem_rdata  in  32  instruction word for the address presented in the previous cycle.
REQ-010 pcF  out  32  PC of the instruction in fetch.
REQ-011 instF  out  32  instruction in fetch, equal to imem_rdata.
REQ-012 predict_takenF  out  1  predictor chose a taken target for pcF.
REQ-013 upd_en / upd_pc[32] / upd_taken / upd_target[32]  in  predictor training port from execute.

Function
REQ-014 pc_next priority SHALL be: RST -> START_PC; fail_predictD|fail_predictE -> nextpc; stall -> pcF; predict_takenF -> BTB target; else pcF+4 (32-bit wrap).
REQ-015 Redirect SHALL win over stall when both are asserted in the same cycle.
REQ-016 imem_addr SHALL equal pc_next combinationally; pcF SHALL register pc_next every edge.
REQ-017 instF SHALL be imem_rdata unmodified; during stall the same address is re-read, so instF stays stable.
REQ-018 BTB entry: valid, tag = pc[31:6], target[32], 2-bit saturating counter; index = pc[5:2] (for 16 entries).
REQ-019 Lookup on pcF: hit = valid & tag match; predict_takenF = hit & counter[1].
REQ-020 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-021 Training on upd_en, tag hit: taken -> increment (saturate at 11) and overwrite target; not taken -> decrement (saturate at 00), target kept.
REQ-022 Training on upd_en, tag miss: taken -> allocate (valid=1, tag, target, counter=10); not taken -> no change.
REQ-023 Training writes take effect at the clock edge; a same-cycle lookup of the written entry sees old contents.
REQ-024 Training SHALL proceed regardless of stall or redirect.
REQ-025 predict_takenF SHALL be forced to 0 while pcF is not word-aligned (pcF[1:0] != 0).

Reset
REQ-026 While RST is high: imem_addr = START_PC, and pcF = START_PC after the edge.
REQ-027 Reset SHALL clear all BTB valid bits; targets and counters need no reset.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL override both. The first post-reset fetch is START_PC with predict_takenF = 0.

Structure
REQ-029 Package rv32i_pkg SHALL hold START_PC, BTB_ENTRIES, the counter encodings, and the BTB entry typedef.
REQ-030 The BTB storage, lookup and training logic SHALL be one sub-module, branch_predictor. fetch_stage holds the PC register and the next-PC mux.

Verification
REQ-031 Reset released, no stall, empty BTB -> imem_addr 0x8000, 0x8004, 0x8008 on successive cycles; predict_takenF = 0.
REQ-032 stall held 3 cycles at pcF=0x8008 -> pcF and imem_addr stay 0x8008; instF stable.
REQ-033 stall=1 and fail_predictE=1, nextpc=0x8100 in the same cycle -> next pcF = 0x8100.
REQ-034 Train upd_pc=0x8010, taken, target 0x8040 -> counter 10. Next fetch of 0x8010 -> predict_takenF = 1 and the following pcF = 0x8040.
REQ-035 Train 0x8010 not-taken once -> counter 01 and predict_takenF = 0 (pcF+4). Train taken 3 times -> counter saturates at 11.
REQ-036 Training 0x8050 (same index as 0x8010, different tag), taken -> entry replaced; 0x8010 misses and 0x8050 predicts taken.
